c1908d_resp_checker: RTL and testbench

Synthesizable response checker for the duplicated c1908 aging experiment. It sits on the output side of the dual-copy circuit and consumes the paired 25-bit response words, copy 1 (N1…) and copy 2 (N2…), once per applied vector. It counts copy-to-copy mismatches, latches the first failing vector index and its syndrome, and optionally compacts copy-1 responses into a 32-bit MISR signature, so long runs do not need per-vector file dumps.

---
 rtl/c1908d_resp_checker.sv | 108 ++++++++++
 tb/tb_c1908d_resp_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/c1908d_resp_checker.sv
// Duplicated c1908 response checker: mismatch count, first failure capture, optional MISR (C1908D_CHK_MISR_EN).
// Latency 1 clk from accepted pair to outputs; accepts 1 pair/clk, never stalls the source.
module c1908d_resp_checker #(
    parameter int OUT_W   = 25,
    parameter int CNT_W   = 20,
    parameter int VEC_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [OUT_W-1:0] resp_a,
    input  logic [OUT_W-1:0] resp_b,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [OUT_W-1:0] first_err_syn,
    output logic [CNT_W-1:0] sample_idx,
    output logic [31:0]      signature
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             launch;
    logic             last;
    logic [OUT_W-1:0] syndrome;
    logic             mismatch;

    assign accept   = (state == RUN) && resp_valid;
    assign launch   = (state != RUN) && start;
    assign last     = accept && (sample_idx == CNT_W'(VEC_LEN - 1));
    assign syndrome = resp_a ^ resp_b;
    assign mismatch = |syndrome;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag      <= 1'b0;
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            first_err_syn <= '0;
            sample_idx    <= '0;
        end else if (launch) begin
            err_flag      <= 1'b0;
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            first_err_syn <= '0;
            sample_idx    <= '0;
        end else if (accept) begin
            sample_idx <= sample_idx + 1'b1;
            if (mismatch) begin
                // Counter sticks at all-ones rather than wrapping on very long runs.
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (!err_flag) begin
                    err_flag      <= 1'b1;
                    first_err_idx <= sample_idx;
                    first_err_syn <= syndrome;
                end
            end
        end
    end

`ifdef C1908D_CHK_MISR_EN
    logic [31:0] sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (launch) begin
            sig <= 32'hFFFF_FFFF;
        end else if (accept) begin
            sig <= {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0) ^ 32'(resp_a);
        end
    end

    assign signature = sig;
`else
    assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_c1908d_resp_checker.sv
// Scoreboard bench for c1908d_resp_checker with directed response pairs.
module tb_c1908d_resp_checker;

    localparam int OUT_W   = 25;
    localparam int CNT_W   = 20;
    localparam int VEC_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             resp_valid;
    logic [OUT_W-1:0] resp_a;
    logic [OUT_W-1:0] resp_b;
    logic             busy;
    logic             done;
    logic             err_flag;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic [OUT_W-1:0] first_err_syn;
    logic [CNT_W-1:0] sample_idx;
    logic [31:0]      signature;

    c1908d_resp_checker #(.OUT_W(OUT_W), .CNT_W(CNT_W), .VEC_LEN(VEC_LEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .resp_valid    (resp_valid),
        .resp_a        (resp_a),
        .resp_b        (resp_b),
        .busy          (busy),
        .done          (done),
        .err_flag      (err_flag),
        .mismatch_cnt  (mismatch_cnt),
        .first_err_idx (first_err_idx),
        .first_err_syn (first_err_syn),
        .sample_idx    (sample_idx),
        .signature     (signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] idx;
        logic [OUT_W-1:0] syn;
        logic [31:0]      sig;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sig_m  = 32'h0;

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [OUT_W-1:0] a);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ {7'b0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sig_m = 32'hFFFF_FFFF;
    endtask

    // counted=1 when the bench expects the DUT to accept this pair into the run.
    task automatic pair(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b, input bit counted);
        resp_valid = 1'b1;
        resp_a     = a;
        resp_b     = b;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        if (counted) sig_m = misr_step(sig_m, a);
    endtask

    task automatic push_exp(input int cnt, input int idx, input logic [OUT_W-1:0] syn);
        exp_t e;
        e.cnt = CNT_W'(cnt);
        e.idx = CNT_W'(idx);
        e.syn = syn;
`ifdef C1908D_CHK_MISR_EN
        e.sig = sig_m;
`else
        e.sig = 32'h0;
`endif
        sb.push_back(e);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", {31'b0, ok}, 32'h1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'b0, busy}, 32'h0);
        chk({tag, "_done"},  {31'b0, done}, 32'h0);
        chk({tag, "_err"},   {31'b0, err_flag}, 32'h0);
        chk({tag, "_cnt"},   32'(mismatch_cnt), 32'h0);
        chk({tag, "_idx"},   32'(first_err_idx), 32'h0);
        chk({tag, "_syn"},   32'(first_err_syn), 32'h0);
        chk({tag, "_smp"},   32'(sample_idx), 32'h0);
        chk({tag, "_sig"},   signature, 32'h0);
    endtask

    // Monitor: each rising edge of done is one completed run to score.
    initial begin
        logic done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("run_busy",  {31'b0, busy}, 32'h0);
                    chk("run_err",   {31'b0, err_flag}, {31'b0, (e.cnt != '0)});
                    chk("run_cnt",   32'(mismatch_cnt), 32'(e.cnt));
                    chk("run_idx",   32'(first_err_idx), 32'(e.idx));
                    chk("run_syn",   32'(first_err_syn), 32'(e.syn));
                    chk("run_smp",   32'(sample_idx), VEC_LEN);
                    chk("run_sig",   signature, e.sig);
                end
            end
            done_q = done;
        end
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp_a     = '0;
        resp_b     = '0;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean run.
        do_start();
        chk("run_busy_rise", {31'b0, busy}, 32'h1);
        for (int i = 0; i < 4; i++) pair(25'h0AAAAAA, 25'h0AAAAAA, 1'b1);
        push_exp(0, 0, 25'h0);
        wait_done();

        // Pairs offered in DONE must not disturb held results.
        pair(25'h0000001, 25'h0000002, 1'b0);
        pair(25'h1234567, 25'h0000000, 1'b0);
        @(negedge clk);
        chk("hold_done", {31'b0, done}, 32'h1);
        chk("hold_cnt",  32'(mismatch_cnt), 32'h0);
        chk("hold_smp",  32'(sample_idx), 32'h4);

        // Single mismatch on pair 2.
        @(posedge clk); #1;
        do_start();
        pair(25'h0000001, 25'h0000001, 1'b1);
        pair(25'h0ABCDEF, 25'h0ABCDEF, 1'b1);
        pair(25'h1234567, 25'h1234577, 1'b1);
        pair(25'h1FFFFFF, 25'h1FFFFFF, 1'b1);
        push_exp(1, 2, 25'h0000010);
        wait_done();

        // Mismatches on pairs 1 and 3, first syndrome retained.
        @(posedge clk); #1;
        do_start();
        pair(25'h0F0F0F0, 25'h0F0F0F0, 1'b1);
        pair(25'h0000000, 25'h1000000, 1'b1);
        pair(25'h1555555, 25'h1555555, 1'b1);
        pair(25'h0000002, 25'h0000003, 1'b1);
        push_exp(2, 1, 25'h1000000);
        wait_done();

        // Abort mid-run with async reset, then a fresh clean run.
        @(posedge clk); #1;
        do_start();
        pair(25'h0000005, 25'h0000004, 1'b1);
        pair(25'h0000006, 25'h0000006, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start();
        pair(25'h0000011, 25'h0000011, 1'b1);
        pair(25'h0000022, 25'h0000022, 1'b1);
        pair(25'h0000033, 25'h0000033, 1'b1);
        pair(25'h0000044, 25'h0000044, 1'b1);
        push_exp(0, 0, 25'h0);
        wait_done();

        // start+valid together: pair dropped; start mid-run ignored; gap tolerated.
        @(posedge clk); #1;
        start      = 1'b1;
        resp_valid = 1'b1;
        resp_a     = 25'h0000005;
        resp_b     = 25'h0000006;
        @(posedge clk); #1;
        start      = 1'b0;
        resp_valid = 1'b0;
        sig_m      = 32'hFFFF_FFFF;
        chk("sv_smp", 32'(sample_idx), 32'h0);
        pair(25'h0000100, 25'h0000101, 1'b1);
        pair(25'h0000200, 25'h0000200, 1'b1);
        @(posedge clk); #1;
        start = 1'b1;
        pair(25'h0000300, 25'h0000300, 1'b1);
        start = 1'b0;
        chk("mid_start_smp", 32'(sample_idx), 32'h3);
        pair(25'h0000400, 25'h0000400, 1'b1);
        push_exp(1, 0, 25'h0000001);
        wait_done();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
